// File: rtl/dac_spi_ctrl.sv
// dac_spi_ctrl: SPI mode-0 write controller for an external 16-bit DAC.
// Ports: clk_i, rst_i (async, high), start_i, data_i in; sclk_o, cs_n_o, mosi_o, busy_o, done_o out.
module dac_spi_ctrl #(
  parameter int DataWidth  = 16,
  parameter int HalfPeriod = 4,
  parameter int DivWidth   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [DataWidth-1:0] data_i,
  output logic                 sclk_o,
  output logic                 cs_n_o,
  output logic                 mosi_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int CntWidth = $clog2(DataWidth + 1);
  localparam logic [DivWidth-1:0] DivLast = DivWidth'(HalfPeriod - 1);
  localparam logic [CntWidth-1:0] BitLast = CntWidth'(DataWidth);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    DONE
  } state_t;

  state_t               state_q;
  logic [DivWidth-1:0]  div_q;
  logic [CntWidth-1:0]  bit_q;
  logic [DataWidth-1:0] shreg_q;

  logic                 phase_end;
  logic [DivWidth-1:0]  div_inc;
  logic [CntWidth-1:0]  bit_nxt;
  logic [DataWidth-1:0] shreg_shl;

  assign phase_end = (div_q == DivLast);
  assign div_inc   = div_q + DivWidth'(1);
  assign bit_nxt   = bit_q + CntWidth'(1);
  assign shreg_shl = shreg_q << 1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      cs_n_o  <= 1'b1;
      sclk_o  <= 1'b0;
      mosi_o  <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          div_q  <= '0;
          bit_q  <= '0;
          cs_n_o <= 1'b1;
          sclk_o <= 1'b0;
          mosi_o <= 1'b0;
          busy_o <= 1'b0;
          if (start_i) begin
            shreg_q <= data_i;
            state_q <= SETUP;
            cs_n_o  <= 1'b0;
            mosi_o  <= data_i[DataWidth-1];
            busy_o  <= 1'b1;
          end
        end
        SETUP: begin
          if (phase_end) begin
            div_q   <= '0;
            state_q <= HIGH;
            sclk_o  <= 1'b1;
          end else begin
            div_q <= div_inc;
          end
        end
        HIGH: begin
          if (phase_end) begin
            div_q  <= '0;
            bit_q  <= bit_nxt;
            sclk_o <= 1'b0;
            if (bit_nxt == BitLast) begin
              state_q <= HOLD;
            end else begin
              // next bit goes out on the falling edge
              shreg_q <= shreg_shl;
              mosi_o  <= shreg_shl[DataWidth-1];
              state_q <= LOW;
            end
          end else begin
            div_q <= div_inc;
          end
        end
        LOW: begin
          if (phase_end) begin
            div_q   <= '0;
            state_q <= HIGH;
            sclk_o  <= 1'b1;
          end else begin
            div_q <= div_inc;
          end
        end
        HOLD: begin
          if (phase_end) begin
            div_q   <= '0;
            state_q <= DONE;
            cs_n_o  <= 1'b1;
            mosi_o  <= 1'b0;
            done_o  <= 1'b1;
          end else begin
            div_q <= div_inc;
          end
        end
        DONE: begin
          div_q   <= '0;
          state_q <= IDLE;
          busy_o  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_ctrl.sv
// tb_dac_spi_ctrl: directed bench for dac_spi_ctrl at HalfPeriod 4 and 1.
// Frames are recovered from the pins and checked against a queue of sent words.
module tb_dac_spi_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  start = '0;
  logic [15:0] din [2];
  logic [1:0]  sclk, csn, mosi, busy, done;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [15:0] wq0[$], wq1[$];
  int          kq0[$], kq1[$];
  int          exp_done[2];

  int          edges[2], first_rise[2], last_rise[2];
  int          cs_first[2], cs_cnt[2], hi_cnt[2], done_cnt[2];
  logic [15:0] word[2];
  logic        psclk[2], pmosi[2], pdone[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dac_spi_ctrl #(.DataWidth(16), .HalfPeriod(4), .DivWidth(8)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .data_i(din[0]),
    .sclk_o(sclk[0]), .cs_n_o(csn[0]), .mosi_o(mosi[0]),
    .busy_o(busy[0]), .done_o(done[0])
  );

  dac_spi_ctrl #(.DataWidth(16), .HalfPeriod(1), .DivWidth(8)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .data_i(din[1]),
    .sclk_o(sclk[1]), .cs_n_o(csn[1]), .mosi_o(mosi[1]),
    .busy_o(busy[1]), .done_o(done[1])
  );

  function automatic int hp(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? wq0.size() : wq1.size();
  endfunction

  task automatic push(input int i, input logic [15:0] w, input int k);
    if (i == 0) begin wq0.push_back(w); kq0.push_back(k); end
    else begin wq1.push_back(w); kq1.push_back(k); end
    exp_done[i]++;
  endtask

  task automatic drop(input int i);
    if (i == 0) begin void'(wq0.pop_front()); void'(kq0.pop_front()); end
    else begin void'(wq1.pop_front()); void'(kq1.pop_front()); end
    exp_done[i]--;
  endtask

  task automatic clr(input int i);
    edges[i] = 0; first_rise[i] = 0; last_rise[i] = 0;
    cs_first[i] = 0; cs_cnt[i] = 0; hi_cnt[i] = 0; word[i] = '0;
  endtask

  // Pin monitor: sampled mid-cycle, one cycle index = edges seen + 1.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        clr(i);
        psclk[i] = 1'b0; pmosi[i] = 1'b0; pdone[i] = 1'b0;
      end else begin
        int c;
        int h;
        int ek;
        logic [15:0] ew;
        c = cyc + 1;
        h = hp(i);
        if (!csn[i]) begin
          if (cs_cnt[i] == 0) cs_first[i] = c;
          cs_cnt[i]++;
        end
        if (sclk[i]) hi_cnt[i]++;
        if (sclk[i] && psclk[i]) chk("mosi_stable", mosi[i], pmosi[i]);
        if (sclk[i] && !psclk[i]) begin
          if (edges[i] == 0) first_rise[i] = c;
          else chk("rise_spacing", c - last_rise[i], 2 * h);
          last_rise[i] = c;
          word[i] = {word[i][14:0], mosi[i]};
          edges[i]++;
        end
        if (done[i]) begin
          done_cnt[i]++;
          chk("done_single", pdone[i], 0);
          chk("done_cs_high", csn[i], 1);
          chk("done_busy", busy[i], 1);
          if (qsize(i) == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            if (i == 0) begin ew = wq0.pop_front(); ek = kq0.pop_front(); end
            else begin ew = wq1.pop_front(); ek = kq1.pop_front(); end
            chk("word", word[i], ew);
            chk("edge_count", edges[i], 16);
            chk("done_cycle", c, ek + 33 * h + 1);
            chk("cs_first_low", cs_first[i], ek + 1);
            chk("cs_low_len", cs_cnt[i], 33 * h);
            chk("sclk_high_len", hi_cnt[i], 16 * h);
            chk("first_rise", first_rise[i], ek + h + 1);
          end
          clr(i);
        end
        psclk[i] = sclk[i]; pmosi[i] = mosi[i]; pdone[i] = done[i];
      end
    end
  end

  task automatic start_frame(input int i, input logic [15:0] d,
                             output int k);
    @(negedge clk);
    start[i] = 1'b1;
    din[i] = d;
    @(posedge clk);
    #1;
    start[i] = 1'b0;
    k = cyc;
    push(i, d, k);
  endtask

  task automatic wait_idle(input int i, input int budget);
    int n;
    n = 0;
    while ((busy[i] || qsize(i) != 0) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", n < budget, 1);
  endtask

  task automatic chk_reset_pins(input int i);
    chk("rst_cs_n", csn[i], 1);
    chk("rst_sclk", sclk[i], 0);
    chk("rst_mosi", mosi[i], 0);
    chk("rst_busy", busy[i], 0);
    chk("rst_done", done[i], 0);
  endtask

  initial begin
    int k;
    int n;
    int dc;
    din[0] = '0;
    din[1] = '0;
    exp_done[0] = 0; exp_done[1] = 0;
    done_cnt[0] = 0; done_cnt[1] = 0;

    // async reset before any clock edge
    #3;
    rst = 1'b1;
    #1;
    chk_reset_pins(0);
    chk_reset_pins(1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single frame
    start_frame(0, 16'hA5C3, k);
    wait_idle(0, 400);

    // start while busy is ignored
    start_frame(0, 16'h00FF, k);
    repeat (49) @(negedge clk);
    start[0] = 1'b1;
    din[0] = 16'h1234;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    wait_idle(0, 400);
    repeat (20) @(negedge clk);
    chk("busy_start_ignored", busy[0], 0);

    // back-to-back with start held high
    @(negedge clk);
    start[0] = 1'b1;
    din[0] = 16'hFFFF;
    @(posedge clk);
    #1;
    k = cyc;
    push(0, 16'hFFFF, k);
    din[0] = 16'h0001;
    push(0, 16'h0001, k + 134);
    repeat (134) @(posedge clk);
    #1;
    start[0] = 1'b0;
    wait_idle(0, 600);

    // reset after the 7th rising edge
    start_frame(0, 16'h5A5A, k);
    n = 0;
    while (edges[0] < 7 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("edge7_timeout", n < 500, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_pins(0);
    drop(0);
    dc = done_cnt[0];
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    #1;
    chk("no_done_after_rst", done_cnt[0], dc);
    chk("idle_after_rst", busy[0], 0);
    start_frame(0, 16'h8001, k);
    wait_idle(0, 400);

    // boundary words at HalfPeriod 1
    start_frame(1, 16'h0000, k);
    wait_idle(1, 100);
    start_frame(1, 16'hFFFF, k);
    wait_idle(1, 100);

    repeat (5) @(negedge clk);
    chk("done_count0", done_cnt[0], exp_done[0]);
    chk("done_count1", done_cnt[1], exp_done[1]);
    chk("queue0_empty", qsize(0), 0);
    chk("queue1_empty", qsize(1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
